mux_arb_n: RTL and testbench
============================

// Module: mux_arb_n
// PURPOSE
//  Parametrised successor to the fixed 8:1 single-bit mux: a CHANNELS:1, WIDTH-bit
//  selector with per-channel valid/ready handshakes and a one-entry registered output.
//  Two modes: fixed select (steered by a select bus) or round-robin arbitration.
//  Sits between datapath producers (ALU/mem/forwarding sources) and a shared consumer.
// PARAMETERS
//  WIDTH     32  data bits per channel
//  CHANNELS   8  number of input channels (>=2)
//  SEL_BITS   3  select/channel-index width; must equal clog2(CHANNELS)
// PORTS
//  clock      in   1                  rising-edge clock
//  reset_n    in   1                  asynchronous, active-low reset
//  mode       in   1                  0 = fixed select, 1 = round-robin
//  select     in   SEL_BITS           channel index used when mode=0
//  in_data    in   CHANNELS*WIDTH     channel k at bits [k*WIDTH +: WIDTH]
//  in_valid   in   CHANNELS           per-channel data valid
//  in_ready   out  CHANNELS           per-channel accept (combinational, one-hot or 0)
//  out_data   out  WIDTH              registered selected word
//  out_chan   out  SEL_BITS           index of channel that supplied out_data
//  out_valid  out  1                  output register holds a word
//  out_ready  in   1                  consumer accepts the word
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
//    Asserting reset mid-transfer discards the held word; no partial state survives.
//  - can_load = !out_valid || out_ready (full-throughput; no bubble on back-to-back).
//  - Grant g (combinational):
//    mode=0: g=select if select<CHANNELS && in_valid[select]; otherwise no grant.
//    mode=1: first k in rr_ptr, rr_ptr+1, ... (mod CHANNELS) with in_valid[k]=1;
//            no grant if in_valid==0.
//  - in_ready[g]=can_load; all other in_ready bits 0; all 0 when no grant.
//  - Input transfer = grant && can_load. Latency 1: next edge loads
//    out_data<=in_data[g], out_chan<=g, out_valid<=1.
//  - If out_valid && out_ready && no input transfer: out_valid<=0, out_data/out_chan hold.
//  - While out_valid && !out_ready: out_data, out_chan, out_valid stable; in_ready all 0.
//  - rr_ptr advances only on an input transfer in mode=1: rr_ptr<=(g+1) mod CHANNELS
//    (g=CHANNELS-1 wraps to 0). rr_ptr holds in mode=0 and across mode changes.
//  - mode/select are sampled combinationally each cycle; a change affects only the
//    next grant, never the word already in the output register.
//  - select>=CHANNELS (non-power-of-2 CHANNELS): nothing accepted, output drains.
//  - Arithmetic: index wrap computed mod CHANNELS, not mod 2**SEL_BITS.
// CONFIGURATION
//  MUX_ARB_XFER_CNT_EN defined: adds port xfer_count out 16 -- count of completed
//    output handshakes (out_valid && out_ready); reset to 0; wraps 16'hFFFF->0;
//    increments by exactly 1 per handshake edge.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: drive reset_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0,
//    out_chan=0 immediately (before next edge); in_ready=0 while reset_n=0.
//  2 Fixed: mode=0, select=5, ch5=32'hDEAD_BEEF valid, out_ready=1 -> in_ready=8'h20;
//    next cycle out_data=32'hDEAD_BEEF, out_chan=5, out_valid=1.
//  3 Round-robin: mode=1, in_valid=8'hFF held, out_ready=1 -> out_chan sequence
//    0,1,...,7,0 on consecutive cycles (wrap-around, one word per cycle).
//  4 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new inputs valid ->
//    in_ready=0, out_data unchanged; raise out_ready -> next word loads same edge.
//  5 Sparse RR: rr_ptr=6, in_valid=8'b0000_0101 -> grant 0, then rr_ptr=1, grant 2.
//  6 MUX_ARB_XFER_CNT_EN: preload count to 16'hFFFE, 3 handshakes -> FFFF, 0000, 0001.

Source files
------------

// File: rtl/mux_arb_n.sv
// ---------------------------------------------------------------------------
// mux_arb_n
//   CHANNELS:1, WIDTH-bit selector with per-channel valid/ready handshakes and
//   a one-entry registered output stage. Two grant modes:
//     mode = 0 : fixed select, steered by the select bus
//     mode = 1 : round-robin, starting the search at rr_ptr
//
// Optional feature macro: MUX_ARB_XFER_CNT_EN
//   When defined, adds output xfer_count[15:0]: a wrapping count of completed
//   output handshakes (out_valid && out_ready). When undefined, the port and
//   counter are absent.
//
// Ports
//   clock      in   1                rising-edge clock
//   reset_n    in   1                asynchronous, active-low reset
//   mode       in   1                0 = fixed select, 1 = round-robin
//   select     in   SEL_BITS         channel index used when mode = 0
//   in_data    in   CHANNELS*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS         per-channel data valid
//   in_ready   out  CHANNELS         per-channel accept (one-hot or zero)
//   out_data   out  WIDTH            registered selected word
//   out_chan   out  SEL_BITS         channel that supplied out_data
//   out_valid  out  1                output register holds a word
//   out_ready  in   1                consumer accepts the word
//   xfer_count out  16               (MUX_ARB_XFER_CNT_EN only) handshake count
// ---------------------------------------------------------------------------
module mux_arb_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_BITS = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_ARB_XFER_CNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  // Channel count at index width plus one bit, so wrap arithmetic can be
  // done mod CHANNELS without overflowing the index.
  localparam logic [SEL_BITS:0] CH_W = (SEL_BITS+1)'(CHANNELS);

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS:0]   rr_idx;
  logic [SEL_BITS:0]   ptr_inc;
  logic [SEL_BITS-1:0] ptr_next;
  logic [SEL_BITS-1:0] grant_idx;
  logic                grant_valid;
  logic                can_load;
  logic                xfer;

  // Unpack the flat input bus into per-channel words.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Output register can take a new word when empty or being drained this edge.
  assign can_load = !out_valid || out_ready;
  assign xfer     = grant_valid && can_load;

  // Grant selection.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    if (!mode) begin
      // Out-of-range selects (non-power-of-2 CHANNELS) never grant.
      if ({1'b0, select} < CH_W) begin
        if (in_valid[select]) begin
          grant_valid = 1'b1;
          grant_idx   = select;
        end
      end
    end else begin
      // Scan rr_ptr, rr_ptr+1, ... wrapping mod CHANNELS; first valid wins.
      for (int i = 0; i < CHANNELS; i++) begin
        rr_idx = {1'b0, rr_ptr} + (SEL_BITS+1)'(i);
        if (rr_idx >= CH_W) begin
          rr_idx = rr_idx - CH_W;
        end
        if (!grant_valid && in_valid[rr_idx[SEL_BITS-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx[SEL_BITS-1:0];
        end
      end
    end
  end

  // Pointer after a round-robin grant: one past the winner, mod CHANNELS.
  assign ptr_inc  = {1'b0, grant_idx} + (SEL_BITS+1)'(1);
  assign ptr_next = (ptr_inc == CH_W) ? '0 : ptr_inc[SEL_BITS-1:0];

  // in_ready is gated by reset_n so nothing appears accepted while the
  // output register is being held in reset.
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = reset_n && grant_valid && can_load &&
                            (grant_idx == SEL_BITS'(gi));
    end
  endgenerate

  // Output register and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_data  <= chan_data[grant_idx];
        out_chan  <= grant_idx;
        out_valid <= 1'b1;
        if (mode) begin
          rr_ptr <= ptr_next;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_XFER_CNT_EN
  // Completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_n
//   Directed bench for mux_arb_n (WIDTH=32, CHANNELS=8). The stimulus process
//   pushes each expected output word into a scoreboard queue when it issues
//   the input; a monitor pops and compares at every output handshake.
// ---------------------------------------------------------------------------
module tb_mux_arb_n;

  localparam int W  = 32;
  localparam int CH = 8;
  localparam int SB = 3;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SB-1:0] chan;
  } exp_t;

  logic            clock;
  logic            reset_n;
  logic            mode;
  logic [SB-1:0]   select;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic [SB-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_ARB_XFER_CNT_EN
  logic [15:0]     xfer_count;
`endif

  int   checks;
  int   errors;
  exp_t sb_q[$];

  mux_arb_n #(.WIDTH(W), .CHANNELS(CH), .SEL_BITS(SB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef MUX_ARB_XFER_CNT_EN
    .xfer_count(xfer_count),
`endif
    .out_ready (out_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog: the run is a fixed sequence of steps, this only guards a hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  task automatic push(input logic [W-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.chan = SB'(c);
    sb_q.push_back(e);
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rise.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual_data=%0h actual_chan=%0d required=none",
                 out_data, out_chan);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (out_data !== e.data || out_chan !== e.chan) begin
          errors++;
          $display("FAIL sb_word actual=%0h/ch%0d required=%0h/ch%0d",
                   out_data, out_chan, e.data, e.chan);
        end else begin
          $display("ok   sb_word %0h/ch%0d", out_data, out_chan);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    mode      = 1'b1;
    select    = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    for (int k = 0; k < CH; k++) set_ch(k, 32'h1000_0000 + k);

    // ---- Reset state; in_ready held low during reset even with valids ----
    #2;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_out_chan",  64'(out_chan),  64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h0);
`ifdef MUX_ARB_XFER_CNT_EN
    check("rst_xfer_count", 64'(xfer_count), 64'h0);
`endif
    in_valid = '0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // ---- Mid-transfer async reset discards held word ----
    mode = 1'b0; select = 3'd4; set_ch(4, 32'hCAFE_0004); in_valid = 8'h10;
    step();
    in_valid = '0;
    check("mid_loaded_valid", 64'(out_valid), 64'h1);
    check("mid_loaded_data",  64'(out_data),  64'hCAFE_0004);
    in_valid = 8'h10;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'h0);
    check("mid_rst_out_data",  64'(out_data),  64'h0);
    check("mid_rst_out_chan",  64'(out_chan),  64'h0);
    check("mid_rst_in_ready",  64'(in_ready),  64'h0);
    in_valid = '0;
    #3;
    reset_n = 1'b1;
    step();

    // ---- Fixed select ----
    out_ready = 1'b1; mode = 1'b0; select = 3'd5;
    set_ch(5, 32'hDEAD_BEEF); in_valid = 8'h20;
    #1;
    check("fix_in_ready", 64'(in_ready), 64'h20);
    push(32'hDEAD_BEEF, 5);
    step();
    in_valid = '0;
    check("fix_out_valid", 64'(out_valid), 64'h1);
    check("fix_out_data",  64'(out_data),  64'hDEAD_BEEF);
    check("fix_out_chan",  64'(out_chan),  64'h5);
    step();
    check("fix_drained", 64'(out_valid), 64'h0);

    // ---- Round-robin, all valid: 0..7 then wrap to 0 ----
    mode = 1'b1;
    for (int k = 0; k < CH; k++) set_ch(k, 32'h1000_0000 + k);
    in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("rr_in_ready_%0d", k), 64'(in_ready), 64'(8'h01 << (k % CH)));
      push(32'h1000_0000 + (k % CH), k % CH);
      step();
    end
    in_valid = '0;
    step();
    // rr_ptr is now 1

    // ---- Backpressure ----
    mode = 1'b0; select = 3'd2; out_ready = 1'b0;
    set_ch(2, 32'hAAAA_0002); in_valid = 8'h04;
    push(32'hAAAA_0002, 2);
    step();
    set_ch(2, 32'hBBBB_0002);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'h0);
      check($sformatf("bp_out_data_%0d", c), 64'(out_data), 64'hAAAA_0002);
      check($sformatf("bp_out_valid_%0d", c), 64'(out_valid), 64'h1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'h04);
    push(32'hBBBB_0002, 2);
    step();
    in_valid = '0;
    check("bp_next_word", 64'(out_data), 64'hBBBB_0002);
    step();

    // ---- Sparse round-robin: move rr_ptr 1 -> 6 via a grant of ch5 ----
    mode = 1'b1; set_ch(5, 32'h5555_0005); in_valid = 8'h20;
    push(32'h5555_0005, 5);
    step();
    set_ch(0, 32'h0000_00A0); set_ch(2, 32'h0000_00A2);
    in_valid = 8'b0000_0101;
    #1;
    check("sparse_grant0", 64'(in_ready), 64'h01);
    push(32'h0000_00A0, 0);
    step();
    check("sparse_grant2", 64'(in_ready), 64'h04);
    push(32'h0000_00A2, 2);
    step();
    in_valid = '0;
    step();
    // rr_ptr is now 3; a mode=0 transfer must not move it
    mode = 1'b0; select = 3'd1; set_ch(1, 32'h0000_00B1); in_valid = 8'h02;
    push(32'h0000_00B1, 1);
    step();
    mode = 1'b1; in_valid = 8'b0000_0110;
    #1;
    check("rr_hold_in_mode0", 64'(in_ready), 64'h02);
    push(32'h0000_00B1, 1);
    step();
    in_valid = '0;
    step();
    step();

`ifdef MUX_ARB_XFER_CNT_EN
    // ---- Handshake counter wrap ----
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    mode = 1'b0; select = 3'd0; set_ch(0, 32'h0000_6666); out_ready = 1'b1;
    in_valid = 8'h01;
    for (int n = 0; n < 65534; n++) begin
      push(32'h0000_6666, 0);
      step();
    end
    in_valid = '0;
    step();
    check("cnt_fffe", 64'(xfer_count), 64'hFFFE);
    for (int n = 0; n < 3; n++) begin
      in_valid = 8'h01;
      push(32'h0000_6666, 0);
      step();
      in_valid = '0;
      step();
      check($sformatf("cnt_wrap_%0d", n), 64'(xfer_count), 64'((16'hFFFF + n) & 16'hFFFF));
    end
`endif

    step();
    step();
    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
